// File: rtl/pair_hmm_pkg.sv
// Shared types for the Pair-HMM floating-point scheduling blocks.
// Operand bundle and scheduler state encoding used by mult_add_scheduler.
package pair_hmm_pkg;

  localparam int FP_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  typedef struct packed {
    logic [FP_W-1:0] lml;
    logic [FP_W-1:0] lmr;
    logic [FP_W-1:0] rml;
    logic [FP_W-1:0] rmr;
  } ma_operands_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from pointer+1 with wrap-around.
// Zero latency; grant is all-zero when no request is present.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(pointer) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/mult_add_scheduler.sv
// Time-shares one MULT_ADD unit between NUM_REQ requesters with round-robin grant.
// Accept->issue 1 cycle, done->response 1 cycle; one operation in flight, watchdog on WAIT.
module mult_add_scheduler
  import pair_hmm_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_lml,
  input  logic [NUM_REQ*FP_W-1:0] req_lmr,
  input  logic [NUM_REQ*FP_W-1:0] req_rml,
  input  logic [NUM_REQ*FP_W-1:0] req_rmr,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]         resp_result,
  output logic                    resp_err,
  output logic                    ma_input_valid,
  output logic [FP_W-1:0]         ma_lml,
  output logic [FP_W-1:0]         ma_lmr,
  output logic [FP_W-1:0]         ma_rml,
  output logic [FP_W-1:0]         ma_rmr,
  input  logic [FP_W-1:0]         ma_result,
  input  logic                    ma_done,
  output logic                    busy,
  output logic                    timeout_flag
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_e       state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gidx_q;
  ma_operands_t       ops_q;
  logic [WD_W-1:0]    wd_q;
  logic [WD_W-1:0]    wd_d;
  logic [FP_W-1:0]    res_q;
  logic               err_q;
  logic               issue_q;
  logic [NUM_REQ-1:0] resp_vld_q;
  logic               flag_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  ma_operands_t       sel_ops;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .pointer (ptr_q),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  always_comb begin
    sel_ops.lml = req_lml[int'(arb_idx)*FP_W +: FP_W];
    sel_ops.lmr = req_lmr[int'(arb_idx)*FP_W +: FP_W];
    sel_ops.rml = req_rml[int'(arb_idx)*FP_W +: FP_W];
    sel_ops.rmr = req_rmr[int'(arb_idx)*FP_W +: FP_W];
  end

  assign wd_d = wd_q + WD_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      gidx_q     <= '0;
      ops_q      <= '0;
      wd_q       <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      issue_q    <= 1'b0;
      resp_vld_q <= '0;
      flag_q     <= 1'b0;
    end else begin
      issue_q    <= 1'b0;
      resp_vld_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            ops_q   <= sel_ops;
            gidx_q  <= arb_idx;
            issue_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A done arriving on the watchdog's final cycle still counts as a normal completion.
          if (ma_done) begin
            res_q      <= ma_result;
            err_q      <= 1'b0;
            resp_vld_q <= NUM_REQ'(1) << gidx_q;
            state_q    <= RESP;
          end else if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
            res_q      <= '0;
            err_q      <= 1'b1;
            flag_q     <= 1'b1;
            resp_vld_q <= NUM_REQ'(1) << gidx_q;
            state_q    <= RESP;
          end else begin
            wd_q <= wd_d;
          end
        end
        RESP: begin
          ptr_q   <= gidx_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE) ? arb_grant : '0;
  assign busy           = (state_q != IDLE);
  assign ma_input_valid = issue_q;
  assign ma_lml         = ops_q.lml;
  assign ma_lmr         = ops_q.lmr;
  assign ma_rml         = ops_q.rml;
  assign ma_rmr         = ops_q.rmr;
  assign resp_valid     = resp_vld_q;
  assign resp_result    = res_q;
  assign resp_err       = err_q;
  assign timeout_flag   = flag_q;

endmodule

// File: tb/tb_mult_add_scheduler.sv
// Randomized bench for mult_add_scheduler against a cycle-level transaction model.
module tb_mult_add_scheduler;

  localparam int N  = 3;
  localparam int TO = 12;
  localparam int W  = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_lml = '0, req_lmr = '0, req_rml = '0, req_rmr = '0;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           resp_err;
  logic           ma_input_valid;
  logic [W-1:0]   ma_lml, ma_lmr, ma_rml, ma_rmr;
  logic [W-1:0]   ma_result = '0;
  logic           ma_done = 1'b0;
  logic           busy;
  logic           timeout_flag;

  mult_add_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lml(req_lml), .req_lmr(req_lmr), .req_rml(req_rml), .req_rmr(req_rmr),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
    .ma_input_valid(ma_input_valid),
    .ma_lml(ma_lml), .ma_lmr(ma_lmr), .ma_rml(ma_rml), .ma_rmr(ma_rmr),
    .ma_result(ma_result), .ma_done(ma_done),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] fp_ma(input logic [63:0] a, b, c, d);
    return $realtobits($bitstoreal(a) * $bitstoreal(b) + $bitstoreal(c) * $bitstoreal(d));
  endfunction

  function automatic logic [63:0] rnd_fp();
    return $realtobits($itor($urandom_range(0, 4095)) / 64.0);
  endfunction

  // Environment: MULT_ADD stand-in with configurable latency or a hang.
  int         cyc = 0;
  int         lat = 3;
  bit         hang = 1'b0;
  int         done_at = -1;
  logic [63:0] pend_res = '0;

  // Reference model state (transaction level).
  int          m_ptr = N - 1;
  bit          m_out = 1'b0;
  int          m_acc_cyc = -100;
  int          m_resp_cyc = -100;
  int          m_g = 0;
  logic [63:0] m_lml, m_lmr, m_rml, m_rmr;
  logic [63:0] m_res = '0;
  bit          m_err = 1'b0;
  bit          m_flag = 1'b0;
  int          n_acc = 0;
  int          n_resp = 0;
  logic [63:0] last_res = '0;
  logic        last_err = 1'b0;

  int          w;
  logic [N-1:0] exp_rdy, exp_resp;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ma_done   = (cyc == done_at);
      ma_result = ma_done ? pend_res : {$urandom, $urandom};
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      m_ptr      = N - 1;
      m_out      = 1'b0;
      m_acc_cyc  = -100;
      m_resp_cyc = -100;
      m_flag     = 1'b0;
    end else begin
      w = -1;
      exp_rdy = '0;
      if (!m_out)
        for (int i = 1; i <= N; i++)
          if (w < 0 && req_valid[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_out));
      chk("issue", 64'(ma_input_valid), 64'(m_out && cyc == m_acc_cyc + 1));
      if (m_out && cyc > m_acc_cyc) begin
        chk("ma_lml", ma_lml, m_lml);
        chk("ma_lmr", ma_lmr, m_lmr);
        chk("ma_rml", ma_rml, m_rml);
        chk("ma_rmr", ma_rmr, m_rmr);
      end
      exp_resp = '0;
      if (m_out && cyc == m_resp_cyc) begin
        exp_resp[m_g] = 1'b1;
        if (m_err) m_flag = 1'b1;
      end
      chk("resp_valid", 64'(resp_valid), 64'(exp_resp));
      chk("timeout_flag", 64'(timeout_flag), 64'(m_flag));
      if (m_out && cyc == m_resp_cyc) begin
        chk("resp_result", resp_result, m_res);
        chk("resp_err", 64'(resp_err), 64'(m_err));
        last_res = resp_result;
        last_err = resp_err;
        n_resp++;
        m_out = 1'b0;
        m_ptr = m_g;
      end
      if (m_out && cyc == m_acc_cyc + 1) begin
        if (!hang && lat <= TO) begin
          m_resp_cyc = cyc + lat + 1;
          m_err      = 1'b0;
          m_res      = fp_ma(m_lml, m_lmr, m_rml, m_rmr);
        end else begin
          m_resp_cyc = cyc + TO + 1;
          m_err      = 1'b1;
          m_res      = '0;
        end
      end
      if (ma_input_valid) begin
        pend_res = fp_ma(ma_lml, ma_lmr, ma_rml, ma_rmr);
        if (!hang) done_at = cyc + lat;
      end
      if (w >= 0) begin
        m_out     = 1'b1;
        m_acc_cyc = cyc;
        m_g       = w;
        m_lml     = req_lml[w*W +: W];
        m_lmr     = req_lmr[w*W +: W];
        m_rml     = req_rml[w*W +: W];
        m_rmr     = req_rmr[w*W +: W];
        n_acc++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scramble_ops();
    for (int k = 0; k < N; k++) begin
      req_lml[k*W +: W] = rnd_fp();
      req_lmr[k*W +: W] = rnd_fp();
      req_rml[k*W +: W] = rnd_fp();
      req_rmr[k*W +: W] = rnd_fp();
    end
  endtask

  task automatic wait_acc(input string tag, input int budget);
    int start = n_acc;
    int k = 0;
    while (n_acc == start && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 64'(n_acc), 64'(start + 1));
  endtask

  task automatic wait_resp(input string tag, input int budget);
    int start = n_resp;
    int k = 0;
    while (n_resp == start && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 64'(n_resp), 64'(start + 1));
  endtask

  task automatic single(input int r, input int l, input bit h);
    lat  = l;
    hang = h;
    scramble_ops();
    req_valid = '0;
    req_valid[r] = 1'b1;
    wait_acc("acc_single", 20);
    req_valid = '0;
    scramble_ops();
    wait_resp("resp_single", TO + 20);
    step(1);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(2);
    chk("rst_ma_lml", ma_lml, 64'd0);
    chk("rst_resp_result", resp_result, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);

    // Directed single request: 0.5*0.5 + 0.5*0.25 = 0.375.
    lat = 4;
    req_lml[0 +: W] = 64'h3FE0000000000000;
    req_lmr[0 +: W] = 64'h3FE0000000000000;
    req_rml[0 +: W] = 64'h3FE0000000000000;
    req_rmr[0 +: W] = 64'h3FD0000000000000;
    req_valid = 3'b001;
    wait_acc("acc_t1", 10);
    req_valid = '0;
    scramble_ops();
    wait_resp("resp_t1", 20);
    chk("t1_result", last_res, 64'h3FD8000000000000);
    chk("t1_err", 64'(last_err), 64'd0);
    step(2);

    // Done coincides with the watchdog limit: normal completion, no flag.
    single(1, TO, 1'b0);
    chk("collide_err", 64'(last_err), 64'd0);
    chk("collide_flag", 64'(timeout_flag), 64'd0);

    // Contention: requesters 0 and 1 held valid, fresh operands every cycle.
    req_valid = 3'b011;
    for (int c = 0; c < 150; c++) begin
      lat = $urandom_range(1, 6);
      scramble_ops();
      step(1);
    end
    req_valid = '0;
    step(TO + 5);

    // Hung datapath, then a normal request afterwards.
    single(2, 1, 1'b1);
    chk("to_err", 64'(last_err), 64'd1);
    chk("to_result", last_res, 64'd0);
    single(0, 2, 1'b0);
    chk("after_to_flag", 64'(timeout_flag), 64'd1);
    chk("after_to_err", 64'(last_err), 64'd0);

    // Reset mid-WAIT with a stale done landing afterwards.
    single(0, 3, 1'b0);
    lat = 10;
    hang = 1'b0;
    req_valid = 3'b010;
    wait_acc("acc_rst", 10);
    req_valid = '0;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(15);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flag", 64'(timeout_flag), 64'd0);
    lat = 2;
    req_valid = 3'b111;
    wait_acc("acc_post_rst", 5);
    chk("post_rst_grant", 64'(m_g), 64'd0);

    // Random valid patterns with occasional hangs and boundary latencies.
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      case ($urandom_range(0, 9))
        0: lat = TO;
        1: lat = TO + 1;
        default: lat = $urandom_range(1, 8);
      endcase
      hang = ($urandom_range(0, 19) == 0);
      scramble_ops();
      step(1);
    end
    req_valid = '0;
    hang = 1'b0;
    step(TO + 10);
    chk("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mult_add_scheduler.md
Name: mult_add_scheduler

Overview:
- Time-shares one MULT_ADD datapath instance (two double multiplies feeding one double add) between NUM_REQ requesters.
- Typical requesters are the f_i and f_d recurrences of one or more Pair-HMM processing elements.
- Accepts operand sets through a valid/ready handshake and picks a winner round-robin.
- Sequences the unit with a one-cycle input_valid pulse, waits for done, then routes the result back to the winner. A watchdog guards against a hung datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before an error response is issued.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_lml  in  NUM_REQ*64  left_mult_left per requester (a_mi/a_md)
- req_lmr  in  NUM_REQ*64  left_mult_right per requester (f_m)
- req_rml  in  NUM_REQ*64  right_mult_left per requester (a_ii/a_dd)
- req_rmr  in  NUM_REQ*64  right_mult_right per requester (f_i/f_d)
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- resp_result  out  64  result for the strobed requester
- resp_err  out  1  qualifies resp_valid; 1 means timeout, result forced to 0
- ma_input_valid  out  1  one-cycle issue pulse to MULT_ADD
- ma_lml, ma_lmr, ma_rml, ma_rmr  out  64 each  latched operands to MULT_ADD
- ma_result  in  64  MULT_ADD result
- ma_done  in  1  MULT_ADD done
- busy  out  1  high in every state except IDLE
- timeout_flag  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 has top priority first; watchdog counter 0.
- IDLE:
  - If any req_valid, the winner g is the first valid requester searching upward from pointer+1 with wrap-around.
  - req_ready[g]=1 combinationally in that same cycle; that is the transfer.
  - On the clock edge: latch g's four operands into the ma_* registers, latch g, go to ISSUE.
  - No req_valid: stay in IDLE with req_ready=0.
- ISSUE: ma_input_valid=1 for exactly this cycle, then go to WAIT and clear the watchdog.
- WAIT:
  - ma_* operands are held stable throughout.
  - On ma_done=1: capture ma_result and go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES, set timeout_flag, capture 0 and err=1, and go to RESP.
- RESP:
  - resp_valid[g]=1 for one cycle, with resp_result and resp_err from the captured values.
  - pointer <= g. Go to IDLE.
- Latency: accept at cycle T, issue at T+1. If MULT_ADD latency is L (done L cycles after input_valid), ma_done arrives at T+1+L and resp_valid at T+2+L. Minimum spacing between accepts is L+3 cycles.
- req_ready is 0 in ISSUE, WAIT and RESP. A new request can only be accepted in the IDLE cycle after RESP; there is no bypass.
- ma_done outside WAIT is ignored. If done and timeout coincide in the same cycle, done wins (normal response, no flag).
- A requester may drop req_valid before it is granted without error. Operands are sampled only in the accept cycle.
- Fairness: after a grant to g, every other valid requester is served before g again.
- Reset mid-operation returns to IDLE immediately; any in-flight result is discarded with no resp_valid. MULT_ADD shares this reset.
- Widths: requester k occupies bits [64k+63:64k] of each packed bus. No arithmetic is performed on data; values pass through unchanged.

Decomposition:
- pair_hmm_pkg holds:
  - FP_W=64.
  - sched_state_e {IDLE, ISSUE, WAIT, RESP}.
  - ma_operands_t, a packed struct of lml, lmr, rml, rmr.
- Sub-module rr_arbiter (NUM_REQ): inputs req and pointer; outputs one-hot grant and index; purely combinational. It is reusable by the other shared FP units.

Test Plan:
- Single request: req0 with lml=lmr=64'h3FE0000000000000 (0.5), rml=64'h3FE0000000000000, rmr=64'h3FD0000000000000 (0.25).
  - Expect: one ma_input_valid pulse one cycle after accept.
  - Expect: resp_valid=2'b01 one cycle after ma_done, resp_result=64'h3FD8000000000000 (0.375), resp_err=0.
- Contention: req0 and req1 held valid continuously after reset. Grants alternate 0,1,0,1; each resp_valid goes to the matching requester with its own result.
- Timeout: bench MULT_ADD model never asserts ma_done.
  - Expect: resp_valid exactly TIMEOUT_CYCLES+1 cycles after the issue cycle, with resp_err=1 and resp_result=0.
  - Expect: timeout_flag stays 1 afterwards, and the next request is still served.
- Done/timeout collision: ma_done asserted on the same cycle the watchdog hits TIMEOUT_CYCLES. Normal response, timeout_flag=0.
- Reset mid-WAIT: assert reset for one cycle while in WAIT.
  - Expect: busy=0, no resp_valid, pointer reset, and a stale ma_done afterwards is ignored.
- Operand stability: change req0 operands and req_valid after accept. ma_* stay at the latched values until RESP, and req_ready stays 0 while busy.
